// File: rtl/rr_pmem_arbiter_if.sv
// Bundle of the two cache-side pmem ports and the single memory-side pmem port.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface rr_pmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              pmem_read_a;
  logic              pmem_write_a;
  logic [ADDR_W-1:0] pmem_address_a;
  logic [LINE_W-1:0] pmem_wdata_a;
  logic              pmem_resp_a;
  logic [LINE_W-1:0] pmem_rdata_a;

  logic              pmem_read_b;
  logic              pmem_write_b;
  logic [ADDR_W-1:0] pmem_address_b;
  logic [LINE_W-1:0] pmem_wdata_b;
  logic              pmem_resp_b;
  logic [LINE_W-1:0] pmem_rdata_b;

  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;

  modport slave (
    input  pmem_read_a, pmem_write_a, pmem_address_a, pmem_wdata_a,
    output pmem_resp_a, pmem_rdata_a,
    input  pmem_read_b, pmem_write_b, pmem_address_b, pmem_wdata_b,
    output pmem_resp_b, pmem_rdata_b,
    input  pmem_resp, pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output pmem_read_a, pmem_write_a, pmem_address_a, pmem_wdata_a,
    input  pmem_resp_a, pmem_rdata_a,
    output pmem_read_b, pmem_write_b, pmem_address_b, pmem_wdata_b,
    input  pmem_resp_b, pmem_rdata_b,
    output pmem_resp, pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/rr_pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between icache (A) and dcache (B),
// with saturating per-port transaction counters.
module rr_pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  rr_pmem_arbiter_if.slave bus,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [1:0]       fsm_state
);
  // Handshake: a cache holds read/write (with address/wdata) steady until it sees its
  // one-cycle resp strobe; a transaction completes in exactly the cycle memory raises
  // pmem_resp while that port is granted. There is no ready/stall signal beyond resp.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_A  = 2'd1,
    BUSY_B  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, next_state;
  logic   last_b;  // 1 when B was served most recently
  logic   req_a, req_b;

  assign req_a     = bus.pmem_read_a | bus.pmem_write_a;
  assign req_b     = bus.pmem_read_b | bus.pmem_write_b;
  assign fsm_state = state;

  assign bus.pmem_rdata_a = bus.pmem_rdata;
  assign bus.pmem_rdata_b = bus.pmem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      count_a <= '0;
      count_b <= '0;
    end else begin
      state <= next_state;
      if (state == BUSY_A && bus.pmem_resp) begin
        last_b <= 1'b0;
        if (count_a != '1) count_a <= count_a + CNT_W'(1);
      end
      if (state == BUSY_B && bus.pmem_resp) begin
        last_b <= 1'b1;
        if (count_b != '1) count_b <= count_b + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state       = state;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.pmem_resp_a  = 1'b0;
    bus.pmem_resp_b  = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) next_state = last_b ? BUSY_A : BUSY_B;
        else if (req_a)     next_state = BUSY_A;
        else if (req_b)     next_state = BUSY_B;
      end
      BUSY_A: begin
        bus.pmem_read    = bus.pmem_read_a;
        bus.pmem_write   = bus.pmem_write_a;
        bus.pmem_address = bus.pmem_address_a;
        bus.pmem_wdata   = bus.pmem_wdata_a;
        bus.pmem_resp_a  = bus.pmem_resp;
        if (bus.pmem_resp) next_state = RELEASE;
      end
      BUSY_B: begin
        bus.pmem_read    = bus.pmem_read_b;
        bus.pmem_write   = bus.pmem_write_b;
        bus.pmem_address = bus.pmem_address_b;
        bus.pmem_wdata   = bus.pmem_wdata_b;
        bus.pmem_resp_b  = bus.pmem_resp;
        if (bus.pmem_resp) next_state = RELEASE;
      end
      // One dead cycle lets the served cache drop its request before re-arbitration.
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
endmodule
